// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_LOAD      = 2'd1,
      ST_WAIT_BUSY = 2'd2,
      ST_WAIT_DONE = 2'd3
   } tx_state_t;

   localparam int C_BUSY_TIMEOUT = 16;

   // Width of a counter that must hold values 0..max_count inclusive.
   function automatic int cnt_width(input int max_count);
      return (max_count < 1) ? 1 : $clog2(max_count + 1);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector: the search starts one past the last
// winner and wraps, so every pending requester is served within G_NUM_REQ grants.
module rr_arbiter #(
   parameter int G_NUM_REQ = 2,
   parameter int G_IDW     = $clog2(G_NUM_REQ)
) (
   input  logic [G_NUM_REQ-1:0] req,
   input  logic [G_IDW-1:0]     last_grant,
   output logic                 any_grant,
   output logic [G_IDW-1:0]     winner
);

   logic [G_IDW:0] idx;

   // Walk the rotated request order and keep the first hit.
   always_comb begin
      any_grant = 1'b0;
      winner    = '0;
      idx       = '0;
      for (int i = 1; i <= G_NUM_REQ; i++) begin
         idx = {1'b0, last_grant} + (G_IDW+1)'(i);
         if (idx >= (G_IDW+1)'(G_NUM_REQ)) begin
            idx = idx - (G_IDW+1)'(G_NUM_REQ);
         end
         if (!any_grant && req[idx[G_IDW-1:0]]) begin
            any_grant = 1'b1;
            winner    = idx[G_IDW-1:0];
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between several byte requesters.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_IDLE      | waiting for a request while the transmitter is free
// ST_LOAD      | strobe o_tx_en and ack the winner for one cycle
// ST_WAIT_BUSY | waiting for the transmitter to raise busy, bounded by timeout
// ST_WAIT_DONE | frame in flight, leave when busy drops
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int G_WORD_WIDTH   = 8,
   parameter int G_NUM_REQ      = 2,
   parameter int G_BUSY_TIMEOUT = C_BUSY_TIMEOUT
) (
   input  logic                              i_clk,
   input  logic                              i_rst,
   input  logic [G_NUM_REQ-1:0]              i_req_valid,
   input  logic [G_NUM_REQ*G_WORD_WIDTH-1:0] i_req_data,
   output logic [G_NUM_REQ-1:0]              o_req_ready,
   output logic                              o_tx_en,
   output logic [G_WORD_WIDTH-1:0]           o_tx_data,
   input  logic                              i_tx_busy,
   output logic [$clog2(G_NUM_REQ)-1:0]      o_grant_id,
   output logic                              o_busy,
   output logic                              o_timeout
);

   localparam int C_IDW = $clog2(G_NUM_REQ);
   localparam int C_CW  = cnt_width(G_BUSY_TIMEOUT);

   tx_state_t       state;
   tx_state_t       state_nxt;
   logic [C_CW-1:0] cnt;
   logic [C_IDW-1:0] last_grant;
   logic [C_IDW-1:0] win;
   logic            any_grant;
   logic            grant;
   logic            timeout_hit;

   rr_arbiter #(
      .G_NUM_REQ (G_NUM_REQ),
      .G_IDW     (C_IDW)
   ) u_rr (
      .req        (i_req_valid),
      .last_grant (last_grant),
      .any_grant  (any_grant),
      .winner     (win)
   );

   assign timeout_hit = (cnt == C_CW'(G_BUSY_TIMEOUT));
   assign o_busy      = (state != ST_IDLE);

   // Next-state decode and Moore-style strobes.
   always_comb begin
      state_nxt   = state;
      grant       = 1'b0;
      o_tx_en     = 1'b0;
      o_req_ready = '0;
      o_timeout   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (any_grant && !i_tx_busy) begin
               grant     = 1'b1;
               state_nxt = ST_LOAD;
            end
         end
         ST_LOAD: begin
            o_tx_en                 = 1'b1;
            o_req_ready[o_grant_id] = 1'b1;
            state_nxt               = ST_WAIT_BUSY;
         end
         ST_WAIT_BUSY: begin
            if (timeout_hit) begin
               o_timeout = 1'b1;
               state_nxt = ST_IDLE;
            end else if (i_tx_busy) begin
               state_nxt = ST_WAIT_DONE;
            end
         end
         ST_WAIT_DONE: begin
            if (!i_tx_busy) begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Capture the winner's byte and index; held until the next grant.
   // last_grant resets to the top index so requester 0 is searched first.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_tx_data  <= '0;
         o_grant_id <= '0;
         last_grant <= C_IDW'(G_NUM_REQ - 1);
      end else if (grant) begin
         o_tx_data  <= i_req_data[int'(win)*G_WORD_WIDTH +: G_WORD_WIDTH];
         o_grant_id <= win;
         last_grant <= win;
      end
   end

   // Busy-wait counter: cleared while loading, saturates at the timeout value.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cnt <= '0;
      end else if (state == ST_LOAD) begin
         cnt <= '0;
      end else if (state == ST_WAIT_BUSY && !i_tx_busy && !timeout_hit) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: stimulus pushes the predicted
// (winner, byte) pair, a negedge monitor pops and compares on every o_tx_en.
module tb_uart_tx_arbiter;

   localparam int N  = 2;
   localparam int W  = 8;
   localparam int TO = 16;

   logic             i_clk = 1'b0;
   logic             i_rst;
   logic [N-1:0]     req_valid;
   logic [N*W-1:0]   req_data;
   logic [N-1:0]     o_req_ready;
   logic             o_tx_en;
   logic [W-1:0]     o_tx_data;
   logic             i_tx_busy;
   logic [$clog2(N)-1:0] o_grant_id;
   logic             o_busy;
   logic             o_timeout;

   typedef struct {
      int           id;
      logic [W-1:0] data;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_pass   = 0;
   int   last_m;

   always #5 i_clk = ~i_clk;

   uart_tx_arbiter #(
      .G_WORD_WIDTH   (W),
      .G_NUM_REQ      (N),
      .G_BUSY_TIMEOUT (TO)
   ) dut (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_req_valid (req_valid),
      .i_req_data  (req_data),
      .o_req_ready (o_req_ready),
      .o_tx_en     (o_tx_en),
      .o_tx_data   (o_tx_data),
      .i_tx_busy   (i_tx_busy),
      .o_grant_id  (o_grant_id),
      .o_busy      (o_busy),
      .o_timeout   (o_timeout)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // Round-robin rule: the lowest pending index above the last winner,
   // otherwise the lowest pending index overall.
   function automatic int model_pick(input logic [N-1:0] v);
      int cands[$];
      for (int k = 0; k < N; k++) if (v[k]) cands.push_back(k);
      if (cands.size() == 0) return -1;
      foreach (cands[j]) if (cands[j] > last_m) return cands[j];
      return cands[0];
   endfunction

   task automatic push_expect();
      int   w;
      exp_t e;
      w = model_pick(req_valid);
      if (w >= 0) begin
         e.id   = w;
         e.data = req_data[w*W +: W];
         exp_q.push_back(e);
         last_m = w;
      end
   endtask

   // Scoreboard monitor.
   always @(negedge i_clk) begin
      if (!i_rst) begin
         if (o_tx_en) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               $display("FAIL sb_unexpected_tx_en: grant_id %0d data 0x%0h with nothing expected at %0t",
                        o_grant_id, o_tx_data, $time);
            end else begin
               mon_e = exp_q.pop_front();
               check("sb_grant_id", 32'(o_grant_id), mon_e.id);
               check("sb_tx_data", 32'(o_tx_data), 32'(mon_e.data));
               check("sb_req_ready", 32'(o_req_ready), 32'(1) << mon_e.id);
            end
         end else if (o_req_ready != '0) begin
            n_checks++;
            $display("FAIL sb_stray_ready: ready 0x%0h without tx_en, expected 0 at %0t", o_req_ready, $time);
         end
      end
   end

   task automatic wait_tx_en(output int lat);
      lat = -1;
      for (int c = 1; c <= 40; c++) begin
         @(negedge i_clk);
         if (o_tx_en) begin
            lat = c;
            break;
         end
      end
      if (lat < 0) begin
         n_checks++;
         $display("FAIL wait_tx_en: no tx_en within 40 cycles, expected one at %0t", $time);
      end
   endtask

   // One transfer plus a modelled UART: busy rises after `lead` cycles in
   // WAIT_BUSY and stays `len` cycles, or never rises (to_mode).
   task automatic xfer(input bit keep, input int lead, input int len, input bit to_mode,
                       output int lat, output int gid);
      logic [N-1:0] acc;
      push_expect();
      wait_tx_en(lat);
      gid = int'(o_grant_id);
      acc = o_req_ready;
      @(negedge i_clk);
      for (int k = 0; k < N; k++) begin
         if (acc[k]) begin
            if (keep) req_data[k*W +: W] = 8'($urandom);
            else      req_valid[k] = 1'b0;
         end
      end
      if (to_mode) begin
         repeat (TO + 1) @(negedge i_clk);
      end else begin
         repeat (lead) @(negedge i_clk);
         i_tx_busy = 1'b1;
         repeat (len) @(negedge i_clk);
         i_tx_busy = 1'b0;
      end
   endtask

   task automatic reset_dut(input bit chk, input logic [N-1:0] v, input logic [N*W-1:0] d);
      i_rst     = 1'b1;
      i_tx_busy = 1'b0;
      req_valid = v;
      req_data  = d;
      repeat (2) @(negedge i_clk);
      if (chk) begin
         check("rst_tx_en", 32'(o_tx_en), 0);
         check("rst_req_ready", 32'(o_req_ready), 0);
         check("rst_tx_data", 32'(o_tx_data), 0);
         check("rst_grant_id", 32'(o_grant_id), 0);
         check("rst_timeout", 32'(o_timeout), 0);
         check("rst_busy", 32'(o_busy), 0);
      end
      last_m = N - 1;
      exp_q.delete();
      i_rst = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      int lat, gid, c;
      i_rst     = 1'b1;
      req_valid = '0;
      req_data  = '0;
      i_tx_busy = 1'b0;
      last_m    = N - 1;

      // Single request, 10-cycle frame.
      reset_dut(1'b1, '0, '0);
      req_valid = 2'b01;
      req_data  = 16'h00A5;
      xfer(1'b0, 0, 10, 1'b0, lat, gid);
      check("single_latency", lat, 1);
      check("single_grant_id", gid, 0);
      check("single_busy_in_done", 32'(o_busy), 1);
      check("single_data_hold", 32'(o_tx_data), 32'h A5);
      @(negedge i_clk);
      check("single_idle_after", 32'(o_busy), 0);
      check("single_grant_hold", 32'(o_grant_id), 0);

      // Contention from reset.
      reset_dut(1'b0, 2'b11, 16'h2211);
      xfer(1'b0, 0, 3, 1'b0, lat, gid);
      check("cont_first_latency", lat, 1);
      check("cont_first_id", gid, 0);
      xfer(1'b0, 1, 3, 1'b0, lat, gid);
      check("cont_busy_fall_to_tx_en", lat, 2);
      check("cont_second_id", gid, 1);

      // Fairness with both requesters permanently valid.
      reset_dut(1'b0, 2'b11, 16'($urandom));
      for (int i = 0; i < 6; i++) begin
         xfer(1'b1, int'($urandom_range(2, 0)), int'($urandom_range(4, 1)), 1'b0, lat, gid);
         check("fair_seq", gid, i % 2);
         check("fair_latency", lat, (i == 0) ? 1 : 2);
      end
      req_valid = '0;
      repeat (3) @(negedge i_clk);

      // Busy-wait timeout.
      reset_dut(1'b0, 2'b10, 16'h5A00);
      push_expect();
      wait_tx_en(lat);
      check("to_latency", lat, 1);
      @(negedge i_clk);
      req_valid = '0;
      check("to_not_early", 32'(o_timeout), 0);
      check("to_in_wait_busy", 32'(o_busy), 1);
      c = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge i_clk);
         c = k;
         if (o_timeout) break;
      end
      check("to_cycles_after_entry", c, TO);
      @(negedge i_clk);
      check("to_pulse_width", 32'(o_timeout), 0);
      check("to_idle", 32'(o_busy), 0);

      // Busy hold-off in IDLE.
      i_tx_busy = 1'b1;
      req_valid = 2'b10;
      req_data  = 16'h3C00;
      repeat (5) begin
         @(negedge i_clk);
         check("holdoff_ready", 32'(o_req_ready), 0);
         check("holdoff_idle", 32'(o_busy), 0);
      end
      i_tx_busy = 1'b0;
      xfer(1'b0, 0, 2, 1'b0, lat, gid);
      check("holdoff_latency", lat, 1);
      check("holdoff_id", gid, 1);

      // Reset abort during WAIT_DONE.
      req_valid = 2'b11;
      req_data  = 16'h7766;
      push_expect();
      wait_tx_en(lat);
      @(negedge i_clk);
      req_data[7:0] = 8'h99;
      i_tx_busy = 1'b1;
      repeat (3) @(negedge i_clk);
      check("abort_in_done", 32'(o_busy), 1);
      i_rst     = 1'b1;
      i_tx_busy = 1'b0;
      @(negedge i_clk);
      check("abort_busy", 32'(o_busy), 0);
      check("abort_tx_en", 32'(o_tx_en), 0);
      check("abort_ready", 32'(o_req_ready), 0);
      check("abort_tx_data", 32'(o_tx_data), 0);
      check("abort_grant_id", 32'(o_grant_id), 0);
      check("abort_timeout", 32'(o_timeout), 0);
      i_rst  = 1'b0;
      last_m = N - 1;
      xfer(1'b0, 0, 2, 1'b0, lat, gid);
      check("abort_regrant_latency", lat, 1);
      check("abort_regrant_id", gid, 0);

      // Randomized traffic against the scoreboard.
      for (int it = 0; it < 40; it++) begin
         for (int k = 0; k < N; k++) begin
            if (!req_valid[k] && ($urandom_range(1, 0) == 1)) begin
               req_valid[k]        = 1'b1;
               req_data[k*W +: W]  = 8'($urandom);
            end
         end
         if (req_valid == '0) begin
            c = int'($urandom_range(N - 1, 0));
            req_valid[c]       = 1'b1;
            req_data[c*W +: W] = 8'($urandom);
         end
         xfer($urandom_range(1, 0) == 1, int'($urandom_range(3, 0)), int'($urandom_range(8, 1)),
              $urandom_range(7, 0) == 0, lat, gid);
      end
      req_valid = '0;
      repeat (5) @(negedge i_clk);
      check("sb_drained", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter G_WORD_WIDTH, default 8, giving the data byte width.
REQ-002 The block SHALL have parameter G_NUM_REQ, default 2, legal range 2..8, giving the number of requesters.
REQ-003 The block SHALL have parameter G_BUSY_TIMEOUT, default 16, giving the maximum number of cycles to wait for i_tx_busy to rise.
REQ-004 The block SHALL have port i_clk, input, 1 bit: clock, all logic on the rising edge.
REQ-005 The block SHALL have port i_rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 The block SHALL have port i_req_valid, input, G_NUM_REQ bits: per-requester byte-pending flag.
REQ-007 The block SHALL have port i_req_data, input, G_NUM_REQ*G_WORD_WIDTH bits: requester k's byte in bits [k*W +: W].
REQ-008 The block SHALL have port o_req_ready, output, G_NUM_REQ bits: one-hot pulse marking byte acceptance.
REQ-009 The block SHALL have port o_tx_en, output, 1 bit: one-cycle start strobe to the UART transmitter.
REQ-010 The block SHALL have port o_tx_data, output, G_WORD_WIDTH bits: byte to transmit.
REQ-011 The block SHALL have port i_tx_busy, input, 1 bit: high while the UART transmitter is shifting a frame.
REQ-012 The block SHALL have port o_grant_id, output, $clog2(G_NUM_REQ) bits: index of the current or last granted requester.
REQ-013 The block SHALL have port o_busy, output, 1 bit: high whenever state is not IDLE.
REQ-014 The block SHALL have port o_timeout, output, 1 bit: one-cycle pulse on busy-wait timeout.

Function
REQ-015 The block SHALL implement FSM states IDLE, LOAD, WAIT_BUSY and WAIT_DONE.
REQ-016 In IDLE with any i_req_valid bit set and i_tx_busy=0, the block SHALL select a winner, capture its byte into o_tx_data, set o_grant_id and enter LOAD on the next edge.
REQ-017 In IDLE with i_tx_busy=1, the block SHALL grant nothing and remain in IDLE.
REQ-018 Arbitration SHALL be round-robin: search starts at (last_grant+1) mod G_NUM_REQ, and last_grant updates only on a grant.
REQ-019 During LOAD, o_tx_en SHALL be 1 and o_req_ready SHALL be 1 only at the winner's bit, both for exactly one cycle; next state SHALL be WAIT_BUSY.
REQ-020 Requesters SHALL hold valid and data stable until ready is seen; a requester may drop valid in the cycle after ready.
REQ-021 Latency SHALL be valid high in IDLE at cycle t -> o_tx_en/o_req_ready high at cycle t+1.
REQ-022 WAIT_BUSY SHALL go to WAIT_DONE when i_tx_busy=1, and SHALL count cycles otherwise.
REQ-023 When the WAIT_BUSY count reaches G_BUSY_TIMEOUT, the block SHALL pulse o_timeout for one cycle and return to IDLE.
REQ-024 The counter SHALL clear on entry to WAIT_BUSY and SHALL never wrap.
REQ-025 WAIT_DONE SHALL return to IDLE on the first cycle with i_tx_busy=0.
REQ-026 In IDLE, the earliest next grant SHALL occur on the following edge, giving back-to-back transfers.
REQ-027 A valid asserted by another requester during LOAD, WAIT_BUSY or WAIT_DONE SHALL be held off and arbitrated in the next IDLE cycle.
REQ-028 o_tx_data and o_grant_id SHALL remain stable from LOAD until the next grant.

Reset
REQ-029 While i_rst=1 on a clock edge, the block SHALL set: state IDLE; o_req_ready 0; o_tx_en 0; o_tx_data 0; o_grant_id 0; o_timeout 0; counter 0; last_grant G_NUM_REQ-1, so requester 0 is first priority.
REQ-030 Reset asserted mid-transfer SHALL abort immediately, with no o_tx_en or o_req_ready pulse in the cycle after reset.

Structure
REQ-031 State enum type and default timeout constant SHALL reside in shared package uart_pkg.
REQ-032 Round-robin selection SHALL be sub-module rr_arbiter: inputs request vector and last_grant; outputs any_grant and winner index; purely combinational.
REQ-033 FSM, counter and data/grant registers SHALL reside in uart_tx_arbiter; target 150-300 lines total.

Verification
REQ-034 Bench SHALL drive single request: req0 valid data 0xA5, busy idle -> next cycle tx_en=1, tx_data=0xA5, ready=01, grant_id=0; busy high 10 cycles -> return IDLE.
REQ-035 Bench SHALL drive contention: req0=0x11 and req1=0x22 held valid from reset -> bytes sent 0x11 then 0x22; second grant one cycle after busy falls.
REQ-036 Bench SHALL check fairness: both requesters permanently valid for 6 transfers -> grant_id sequence 0,1,0,1,0,1.
REQ-037 Bench SHALL check timeout: grant with i_tx_busy tied 0 -> o_timeout pulse exactly 16 cycles after WAIT_BUSY entry, then IDLE, o_busy=0.
REQ-038 Bench SHALL check busy hold-off: i_tx_busy=1 in IDLE with req1 valid -> no ready until busy low, then grant on next edge.
REQ-039 Bench SHALL check reset abort: i_rst during WAIT_DONE -> IDLE, all outputs 0, next grant goes to requester 0 when both are valid.
